// File: rtl/xbar_burst_arbiter.sv
// Burst arbiter for one crossbar output. Picks the queue with the best
// privilege/length and grants it a capped burst of pops under back-pressure.
module xbar_burst_arbiter #(
   parameter int NUM_PORTS   = 8,
   parameter int PORT_WIDTH  = 3,
   parameter int LEN_WIDTH   = 10,
   parameter int MAX_BURST   = 16,
   parameter int BURST_WIDTH = 5
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_PORTS*LEN_WIDTH-1:0] q_len,
   input  logic [NUM_PORTS-1:0]           q_privil,
   input  logic                           dst_ready,
   output logic                           grant_valid,
   output logic [PORT_WIDTH-1:0]          grant_id,
   output logic [NUM_PORTS-1:0]           pop,
   output logic                           burst_done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } state_t;

   localparam logic [LEN_WIDTH-1:0]   LEN_ZERO  = {LEN_WIDTH{1'b0}};
   localparam logic [LEN_WIDTH-1:0]   LEN_CAP   = LEN_WIDTH'(MAX_BURST);
   localparam logic [BURST_WIDTH-1:0] CNT_CAP   = BURST_WIDTH'(MAX_BURST);
   localparam logic [BURST_WIDTH-1:0] CNT_ONE   = BURST_WIDTH'(1);
   localparam logic [NUM_PORTS-1:0]   POP_ZERO  = {NUM_PORTS{1'b0}};

   state_t                 state_r, state_s;
   logic                   grant_valid_r, grant_valid_s;
   logic [PORT_WIDTH-1:0]  grant_id_r, grant_id_s;
   logic [BURST_WIDTH-1:0] burst_cnt_r, burst_cnt_s;
   logic                   burst_done_r, burst_done_s;

   logic                   win_found_s;
   logic                   win_priv_s;
   logic [LEN_WIDTH-1:0]   win_len_s;
   logic [PORT_WIDTH-1:0]  win_id_s;
   logic [BURST_WIDTH-1:0] burst_init_s;

   // Ascending scan with >= so that on a full tie the higher index wins.
   always_comb begin
      win_found_s = 1'b0;
      win_priv_s  = 1'b0;
      win_len_s   = LEN_ZERO;
      win_id_s    = {PORT_WIDTH{1'b0}};
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (q_len[i*LEN_WIDTH +: LEN_WIDTH] != LEN_ZERO) begin
            if (!win_found_s || (q_privil[i] && !win_priv_s) ||
                ((q_privil[i] == win_priv_s) &&
                 (q_len[i*LEN_WIDTH +: LEN_WIDTH] >= win_len_s))) begin
               win_found_s = 1'b1;
               win_priv_s  = q_privil[i];
               win_len_s   = q_len[i*LEN_WIDTH +: LEN_WIDTH];
               win_id_s    = PORT_WIDTH'(i);
            end else begin
               win_found_s = win_found_s;
            end
         end else begin
            win_found_s = win_found_s;
         end
      end
   end

   // Burst length snapshot: min(winner length, MAX_BURST) compared at full length width.
   always_comb begin
      if (win_len_s > LEN_CAP) begin
         burst_init_s = CNT_CAP;
      end else begin
         burst_init_s = win_len_s[BURST_WIDTH-1:0];
      end
   end

   // Next-state and next-output logic for the IDLE/GRANT/GAP sequencer.
   always_comb begin
      state_s       = state_r;
      grant_valid_s = grant_valid_r;
      grant_id_s    = grant_id_r;
      burst_cnt_s   = burst_cnt_r;
      burst_done_s  = 1'b0;
      case (state_r)
         IDLE: begin
            if (win_found_s) begin
               state_s       = GRANT;
               grant_valid_s = 1'b1;
               grant_id_s    = win_id_s;
               burst_cnt_s   = burst_init_s;
            end else begin
               state_s = IDLE;
            end
         end
         GRANT: begin
            if (dst_ready) begin
               burst_cnt_s = burst_cnt_r - CNT_ONE;
               if (burst_cnt_r == CNT_ONE) begin
                  state_s       = GAP;
                  grant_valid_s = 1'b0;
                  burst_done_s  = 1'b1;
               end else begin
                  state_s = GRANT;
               end
            end else begin
               state_s = GRANT;
            end
         end
         GAP: begin
            state_s = IDLE;
         end
         default: begin
            state_s       = IDLE;
            grant_valid_s = 1'b0;
            burst_cnt_s   = {BURST_WIDTH{1'b0}};
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r       <= IDLE;
         grant_valid_r <= 1'b0;
         grant_id_r    <= {PORT_WIDTH{1'b0}};
         burst_cnt_r   <= {BURST_WIDTH{1'b0}};
         burst_done_r  <= 1'b0;
      end else begin
         state_r       <= state_s;
         grant_valid_r <= grant_valid_s;
         grant_id_r    <= grant_id_s;
         burst_cnt_r   <= burst_cnt_s;
         burst_done_r  <= burst_done_s;
      end
   end

   // One-hot pop toward the granted queue, killed as soon as reset rises.
   always_comb begin
      pop = POP_ZERO;
      if (grant_valid_r && dst_ready && !rst) begin
         pop[grant_id_r] = 1'b1;
      end else begin
         pop = POP_ZERO;
      end
   end

   assign grant_valid = grant_valid_r;
   assign grant_id    = grant_id_r;
   assign burst_done  = burst_done_r;

endmodule

// File: tb/tb_xbar_burst_arbiter.sv
// Directed self-checking bench for xbar_burst_arbiter.
module tb_xbar_burst_arbiter;

   logic        clk;
   logic        rst;
   logic [79:0] q_len;
   logic [7:0]  q_privil;
   logic        dst_ready;
   logic        grant_valid;
   logic [2:0]  grant_id;
   logic [7:0]  pop;
   logic        burst_done;

   int checks;
   int failures;
   int pops_seen;
   int pops_model;

   xbar_burst_arbiter #(
      .NUM_PORTS(8), .PORT_WIDTH(3), .LEN_WIDTH(10), .MAX_BURST(16), .BURST_WIDTH(5)
   ) dut (
      .clk(clk), .rst(rst), .q_len(q_len), .q_privil(q_privil),
      .dst_ready(dst_ready), .grant_valid(grant_valid), .grant_id(grant_id),
      .pop(pop), .burst_done(burst_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks = checks + 1;
      assert (obs === exp) else begin
         failures = failures + 1;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_len(input int idx, input int val);
      q_len[idx*10 +: 10] = 10'(val);
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      rst       = 1'b1;
      q_len     = 80'd0;
      q_privil  = 8'd0;
      dst_ready = 1'b1;

      // 1: reset holds everything off even with a candidate present
      set_len(3, 5);
      tick(); tick();
      chk("rst_gv",   32'(grant_valid), 32'd0);
      chk("rst_pop",  32'(pop),         32'd0);
      chk("rst_done", 32'(burst_done),  32'd0);
      chk("rst_id",   32'(grant_id),    32'd0);
      rst = 1'b0;
      tick();
      chk("t1_gv",  32'(grant_valid), 32'd1);
      chk("t1_id",  32'(grant_id),    32'd3);
      chk("t1_pop", 32'(pop),         32'h08);
      tick();
      chk("t1_pop2", 32'(pop), 32'h08);
      rst = 1'b1;
      #1;
      chk("midrst_pop", 32'(pop),         32'd0);
      chk("midrst_gv",  32'(grant_valid), 32'd0);
      q_len = 80'd0;
      tick();
      rst = 1'b0;
      tick();
      chk("post_rst_gv", 32'(grant_valid), 32'd0);
      chk("post_rst_pop", 32'(pop),        32'd0);

      // 2: single queue of 3
      set_len(2, 3);
      tick();
      chk("t2_gv",   32'(grant_valid), 32'd1);
      chk("t2_id",   32'(grant_id),    32'd2);
      chk("t2_pop0", 32'(pop),         32'h04);
      chk("t2_done0", 32'(burst_done), 32'd0);
      q_len = 80'd0;
      tick();
      chk("t2_pop1", 32'(pop), 32'h04);
      tick();
      chk("t2_pop2", 32'(pop), 32'h04);
      tick();
      chk("t2_gap_gv",   32'(grant_valid), 32'd0);
      chk("t2_gap_pop",  32'(pop),         32'd0);
      chk("t2_gap_done", 32'(burst_done),  32'd1);
      tick();
      chk("t2_idle_done", 32'(burst_done),  32'd0);
      chk("t2_idle_gv",   32'(grant_valid), 32'd0);

      // 3: privilege beats length; empty privileged port is excluded
      set_len(1, 2);  q_privil[1] = 1'b1;
      set_len(5, 40);
      tick();
      chk("t3_id_priv", 32'(grant_id),    32'd1);
      chk("t3_gv",      32'(grant_valid), 32'd1);
      set_len(1, 0);
      tick();
      chk("t3_pop1", 32'(pop), 32'h02);
      tick();
      chk("t3_done", 32'(burst_done), 32'd1);
      tick();
      chk("t3_idle_gv", 32'(grant_valid), 32'd0);
      tick();
      chk("t3_id_np", 32'(grant_id),    32'd5);
      chk("t3_gv2",   32'(grant_valid), 32'd1);
      q_len = 80'd0;
      q_privil = 8'd0;
      for (int k = 0; k < 15; k++) begin
         tick();
         chk("t3_burst_pop", 32'(pop), 32'h20);
      end
      tick();
      chk("t3_cap_done", 32'(burst_done),  32'd1);
      chk("t3_cap_gv",   32'(grant_valid), 32'd0);
      tick();

      // 4: length order and higher-index tie break
      set_len(0, 7); set_len(6, 7); set_len(4, 3);
      tick();
      chk("t4_id",  32'(grant_id), 32'd6);
      chk("t4_pop", 32'(pop),      32'h40);
      q_len = 80'd0;
      for (int k = 0; k < 6; k++) begin
         tick();
      end
      chk("t4_last_pop", 32'(pop), 32'h40);
      tick();
      chk("t4_done", 32'(burst_done), 32'd1);
      tick();

      // 5: cap at 16 pops with alternating back-pressure, then re-grant
      set_len(7, 100);
      tick();
      chk("t5_id", 32'(grant_id), 32'd7);
      pops_seen  = 0;
      pops_model = 0;
      for (int c = 0; c < 31; c++) begin
         dst_ready = (c % 2 == 0);
         #1;
         chk("t5_pop", 32'(pop), (pops_model < 16 && dst_ready) ? 32'h80 : 32'd0);
         if (pop == 8'h80) pops_seen = pops_seen + 1;
         if (pops_model < 16 && dst_ready) pops_model = pops_model + 1;
         tick();
      end
      chk("t5_pop_count", 32'(pops_seen),   32'd16);
      chk("t5_done",      32'(burst_done),  32'd1);
      chk("t5_gap_gv",    32'(grant_valid), 32'd0);
      dst_ready = 1'b1;
      tick();
      chk("t5_idle_gv", 32'(grant_valid), 32'd0);
      tick();
      chk("t5_regrant_gv", 32'(grant_valid), 32'd1);
      chk("t5_regrant_id", 32'(grant_id),    32'd7);
      rst = 1'b1;
      #1;
      chk("t5_rst_pop", 32'(pop), 32'd0);
      q_len = 80'd0;
      tick();
      rst = 1'b0;

      // 6: no candidates for 20 cycles
      for (int k = 0; k < 20; k++) begin
         tick();
         chk("t6_gv",  32'(grant_valid), 32'd0);
         chk("t6_pop", 32'(pop),         32'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
